// File: rtl/uart_wb_arbiter_pkg.sv
// Shared definitions for the two-requester UART bus arbiter: register map,
// bus write polarity and FSM state encoding.
package uart_wb_arbiter_pkg;

  localparam logic [1:0] UART_ADDR_TX  = 2'd0;
  localparam logic [1:0] UART_ADDR_RX  = 2'd1;
  localparam logic [1:0] UART_ADDR_DIV = 2'd2;

  localparam logic UART_WE_WRITE = 1'b0;
  localparam logic UART_WE_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    FINISH  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_wb_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, and a tie goes to the
// requester that was not served last (last=1 means r1 was served last).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Arbitrates two requesters onto a single UART register port using a
// strobe / bus-clock handshake with an ack timeout.
module uart_wb_arbiter
  import uart_wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_req,
  input  logic [1:0] r0_addr,
  input  logic [7:0] r0_wdata,
  input  logic       r0_we,
  input  logic       r1_req,
  input  logic [1:0] r1_addr,
  input  logic [7:0] r1_wdata,
  input  logic       r1_we,
  output logic       r0_done,
  output logic       r1_done,
  output logic       r0_err,
  output logic       r1_err,
  output logic [7:0] rdata,
  output logic [1:0] grant,
  output logic [1:0] m_addr,
  output logic [7:0] m_wdata,
  output logic       m_we,
  output logic       m_stb,
  output logic       m_clk,
  input  logic       m_ack,
  input  logic [7:0] m_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  arb_state_t state_reg, state_next;
  logic [1:0] grant_reg;
  logic       last_reg;
  logic [7:0] wait_reg;
  logic       timeout_reg;
  logic [7:0] rdata_reg;
  logic [1:0] m_addr_reg;
  logic [7:0] m_wdata_reg;
  logic       m_we_reg;

  logic [1:0] req_vec;
  logic [1:0] rr_gnt;
  logic       wait_expired;
  logic       timeout_hit;
  logic [1:0] done_vec;
  logic [1:0] err_vec;

  assign req_vec = {r1_req, r0_req};

  rr_arb2 u_rr_arb2 (
    .req  (req_vec),
    .last (last_reg),
    .gnt  (rr_gnt)
  );

  assign wait_expired = (wait_reg == WAIT_LAST);
  // A timeout is only taken when the slave has not completed that edge in the same cycle.
  assign timeout_hit  = wait_expired &&
                        (((state_reg == ISSUE) && !m_ack) ||
                         ((state_reg == RELEASE) && m_ack));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_vec) state_next = ISSUE;
      ISSUE:   if (m_ack) state_next = RELEASE;
               else if (wait_expired) state_next = FINISH;
      RELEASE: if (!m_ack || wait_expired) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      grant_reg   <= 2'b00;
      last_reg    <= 1'b1;
      wait_reg    <= 8'd0;
      timeout_reg <= 1'b0;
      rdata_reg   <= 8'd0;
      m_addr_reg  <= UART_ADDR_TX;
      m_wdata_reg <= 8'd0;
      m_we_reg    <= UART_WE_WRITE;
    end else begin
      state_reg <= state_next;

      if (state_next != state_reg) begin
        wait_reg <= 8'd0;
      end else if ((state_reg == ISSUE) || (state_reg == RELEASE)) begin
        wait_reg <= wait_reg + 8'd1;
      end

      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end else if (state_reg == IDLE) begin
        timeout_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            grant_reg   <= rr_gnt;
            m_addr_reg  <= rr_gnt[1] ? r1_addr  : r0_addr;
            m_wdata_reg <= rr_gnt[1] ? r1_wdata : r0_wdata;
            m_we_reg    <= rr_gnt[1] ? r1_we    : r0_we;
          end
        end
        ISSUE: begin
          if (m_ack) rdata_reg <= m_rdata;
        end
        FINISH: begin
          // Timeouts advance the round-robin exactly like completions.
          grant_reg <= 2'b00;
          last_reg  <= grant_reg[1];
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_pulse
    assign done_vec[gi] = (state_reg == FINISH) && !timeout_reg && grant_reg[gi];
    assign err_vec[gi]  = (state_reg == FINISH) &&  timeout_reg && grant_reg[gi];
  end

  assign r0_done = done_vec[0];
  assign r1_done = done_vec[1];
  assign r0_err  = err_vec[0];
  assign r1_err  = err_vec[1];
  assign rdata   = rdata_reg;
  assign grant   = grant_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign m_we    = m_we_reg;
  assign m_stb   = (state_reg == ISSUE) || (state_reg == RELEASE);
  assign m_clk   = (state_reg == ISSUE);

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed and randomized bench for uart_wb_arbiter with an abstract
// round-robin / transaction-timing reference model.
module tb_uart_wb_arbiter;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r0_req = 1'b0, r1_req = 1'b0;
  logic [1:0] r0_addr = 2'd0, r1_addr = 2'd0;
  logic [7:0] r0_wdata = 8'd0, r1_wdata = 8'd0;
  logic       r0_we = 1'b0, r1_we = 1'b0;
  logic       r0_done, r1_done, r0_err, r1_err;
  logic [7:0] rdata;
  logic [1:0] grant;
  logic [1:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_we, m_stb, m_clk, m_ack;
  logic [7:0] m_rdata;

  logic       ack_en = 1'b1;
  logic [7:0] slave_rdata = 8'd0;

  int checks = 0;
  int errors = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  // Slave answers within the same bus-clock phase when enabled.
  assign m_ack   = ack_en & m_stb & m_clk;
  assign m_rdata = slave_rdata;

  uart_wb_arbiter #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .r0_req   (r0_req),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_we    (r0_we),
    .r1_req   (r1_req),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_we    (r1_we),
    .r0_done  (r0_done),
    .r1_done  (r1_done),
    .r0_err   (r0_err),
    .r1_err   (r1_err),
    .rdata    (rdata),
    .grant    (grant),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_we     (m_we),
    .m_stb    (m_stb),
    .m_clk    (m_clk),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    if (r0_req && r1_req) return (model_last == 1) ? 0 : 1;
    return r0_req ? 0 : 1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 8'(grant), 8'd0);
    check({tag, "_pulses"}, 8'({r1_err, r0_err, r1_done, r0_done}), 8'd0);
    check({tag, "_stb"}, 8'(m_stb), 8'd0);
  endtask

  task automatic rand_req(input int who);
    if (who == 0) begin
      r0_req = 1'b1; r0_addr = 2'($urandom_range(2, 0));
      r0_wdata = 8'($urandom); r0_we = 1'($urandom_range(1, 0));
    end else begin
      r1_req = 1'b1; r1_addr = 2'($urandom_range(2, 0));
      r1_wdata = 8'($urandom); r1_we = 1'($urandom_range(1, 0));
    end
  endtask

  // Called in an IDLE cycle with requests already set; returns in the FINISH cycle.
  task automatic serve_one(input bit drop, input bit tamper, input bit fast, input logic [7:0] sdata);
    int w;
    logic [1:0] ea, g;
    logic [7:0] ed;
    logic ewe;
    w   = model_pick();
    ea  = (w == 0) ? r0_addr  : r1_addr;
    ed  = (w == 0) ? r0_wdata : r1_wdata;
    ewe = (w == 0) ? r0_we    : r1_we;
    g   = (w == 0) ? 2'b01 : 2'b10;
    slave_rdata = sdata;
    tick();
    check("issue_grant", 8'(grant), 8'(g));
    check("issue_addr", 8'(m_addr), 8'(ea));
    check("issue_wdata", m_wdata, ed);
    check("issue_we", 8'(m_we), 8'(ewe));
    check("issue_stb_clk", 8'({m_stb, m_clk}), 8'b11);
    check("issue_pulses", 8'({r1_err, r0_err, r1_done, r0_done}), 8'd0);
    if (tamper) begin
      if (w == 0) begin r0_req = 1'b0; r0_wdata = 8'hFF; end
      else        begin r1_req = 1'b0; r1_wdata = 8'hFF; end
    end
    if (fast) begin
      tick();
      check("release_stb_clk", 8'({m_stb, m_clk}), 8'b10);
      check("release_wdata", m_wdata, ed);
      check("release_pulses", 8'({r1_err, r0_err, r1_done, r0_done}), 8'd0);
      tick();
      check("finish_done", 8'({r1_done, r0_done}), 8'(g));
      check("finish_err", 8'({r1_err, r0_err}), 8'd0);
      check("finish_stb_clk", 8'({m_stb, m_clk}), 8'b00);
      check("finish_wdata", m_wdata, ed);
      if (ewe) check("finish_rdata", rdata, sdata);
    end else begin
      repeat (TMO - 1) begin
        tick();
        check("wait_stb_clk", 8'({m_stb, m_clk}), 8'b11);
        check("wait_err", 8'({r1_err, r0_err}), 8'd0);
      end
      tick();
      check("timeout_err", 8'({r1_err, r0_err}), 8'(g));
      check("timeout_done", 8'({r1_done, r0_done}), 8'd0);
      check("timeout_stb_clk", 8'({m_stb, m_clk}), 8'b00);
    end
    model_last = w;
    if (drop) begin
      if (w == 0) r0_req = 1'b0;
      else        r1_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check("rst_grant", 8'(grant), 8'd0);
    check("rst_stb_clk", 8'({m_stb, m_clk}), 8'd0);
    check("rst_m_fields", 8'({m_we, m_addr}), 8'd0);
    check("rst_m_wdata", m_wdata, 8'd0);
    check("rst_pulses", 8'({r1_err, r0_err, r1_done, r0_done}), 8'd0);
    check("rst_rdata", rdata, 8'd0);
    reset = 1'b0;

    // Single r0 write to TX.
    r0_req = 1'b1; r0_addr = 2'd0; r0_wdata = 8'h41; r0_we = 1'b0;
    serve_one(1, 0, 1, 8'h00);
    tick(); check_idle("idle_a");

    // r1 read of RX.
    r1_req = 1'b1; r1_addr = 2'd1; r1_wdata = 8'h00; r1_we = 1'b1;
    serve_one(1, 0, 1, 8'h5A);
    tick(); check_idle("idle_b");

    // Both requesting continuously: alternation.
    r0_req = 1'b1; r0_addr = 2'd2; r0_wdata = 8'h12; r0_we = 1'b0;
    r1_req = 1'b1; r1_addr = 2'd1; r1_wdata = 8'h34; r1_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rr_expect_winner", 8'(model_pick()), 8'(i % 2));
      serve_one(0, 0, 1, 8'(8'hA0 + i));
      tick(); check("rr_idle_grant", 8'(grant), 8'd0);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick(); check_idle("idle_c");

    // Slave never acks; the other requester is served next.
    ack_en = 1'b0;
    r0_req = 1'b1; r1_req = 1'b1;
    serve_one(0, 0, 0, 8'h00);
    ack_en = 1'b1;
    tick(); check_idle("idle_after_err");
    serve_one(1, 0, 1, 8'h77);
    tick(); check_idle("idle_d");
    serve_one(1, 0, 1, 8'h66);
    tick(); check_idle("idle_e");
    // Lone r0 again right after being served.
    r0_req = 1'b1; r0_wdata = 8'h9C;
    serve_one(1, 0, 1, 8'h11);
    tick(); check_idle("idle_f");

    // Reset during RELEASE.
    r1_req = 1'b1; r1_addr = 2'd1; r1_we = 1'b1; slave_rdata = 8'hC3;
    tick();
    check("pre_rst_grant", 8'(grant), 8'b10);
    tick();
    check("pre_rst_stb_clk", 8'({m_stb, m_clk}), 8'b10);
    reset = 1'b1;
    tick();
    check("mid_rst_grant", 8'(grant), 8'd0);
    check("mid_rst_stb_clk", 8'({m_stb, m_clk}), 8'd0);
    check("mid_rst_m_fields", 8'({m_we, m_addr}), 8'd0);
    check("mid_rst_m_wdata", m_wdata, 8'd0);
    check("mid_rst_rdata", rdata, 8'd0);
    check("mid_rst_pulses", 8'({r1_err, r0_err, r1_done, r0_done}), 8'd0);
    tick();
    check("mid_rst_pulses2", 8'({r1_err, r0_err, r1_done, r0_done}), 8'd0);
    reset = 1'b0;
    model_last = 1;
    r0_req = 1'b1; r0_addr = 2'd0; r0_wdata = 8'h55; r0_we = 1'b0;
    check("post_rst_winner", 8'(model_pick()), 8'd0);
    serve_one(1, 0, 1, 8'h00);
    tick(); check("idle_g_grant", 8'(grant), 8'd0);
    serve_one(1, 0, 1, 8'h2E);
    tick(); check_idle("idle_h");

    // Granted requester drops req and changes wdata during ISSUE.
    r0_req = 1'b1; r0_addr = 2'd0; r0_wdata = 8'h3C; r0_we = 1'b0;
    serve_one(1, 1, 1, 8'h00);

    // Randomized traffic.
    for (int it = 0; it < 16; it++) begin
      tick(); check_idle("rnd_idle");
      if (!r0_req && ($urandom_range(1, 0) == 1)) rand_req(0);
      if (!r1_req && ($urandom_range(1, 0) == 1)) rand_req(1);
      if (!r0_req && !r1_req) rand_req(int'($urandom_range(1, 0)));
      serve_one(1, 0, 1, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_wb_arbiter.md
UART_WB_ARBITER -- requirements
Module: uart_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of clk cycles to wait for m_ack at either handshake edge before aborting.
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 r0_req, r1_req  in  1 each  requester holds high until its done or err pulse.
REQ-005 r0_addr, r1_addr  in  2 each  UART register: 0=TX data, 1=RX data, 2=freq divider.
REQ-006 r0_wdata, r1_wdata  in  8 each  write data.
REQ-007 r0_we, r1_we  in  1 each  0=write, 1=read, matching UART polarity.
REQ-008 r0_done, r1_done  out  1 each  one-cycle completion pulse.
REQ-009 r0_err, r1_err  out  1 each  one-cycle timeout pulse.
REQ-010 rdata  out  8  read data, valid in the cycle of any done pulse.
REQ-011 grant  out  2  one-hot owner of the UART port; 00 when idle.
REQ-012 m_addr, m_wdata, m_we  out  2/8/1  registered copies of the granted requester's fields.
REQ-013 m_stb, m_clk  out  1 each  UART bus strobe and bus phase clock.
REQ-014 m_ack  in  1  UART acknowledge.
REQ-015 m_rdata  in  8  UART read data.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, RELEASE, and FINISH.
REQ-017 In IDLE with at least one req high, the FSM SHALL latch the winner's addr, wdata, and we into m_*, set grant, and go to ISSUE; outputs change on the next edge.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset, r0 wins a tie.
REQ-019 A lone requester SHALL be granted regardless of round-robin state.
REQ-020 ISSUE: m_stb=1, m_clk=1; on m_ack=1, capture m_rdata into an internal register and go to RELEASE.
REQ-021 RELEASE: m_stb=1, m_clk=0; on m_ack=0, go to FINISH.
REQ-022 FINISH: m_stb=0, and the FSM SHALL
  - pulse done and drive rdata for the granted requester for one cycle;
  - record that requester as last served;
  - clear grant;
  - return to IDLE.
REQ-023 The minimum transaction SHALL be 4 cycles (IDLE decision, ISSUE, RELEASE, FINISH) with a 1-cycle-ack slave; the next grant SHALL not be earlier than the cycle after FINISH.
REQ-024 A requester SHALL not be re-granted in the IDLE cycle immediately following its own FINISH if the other req is high.
REQ-025 An 8-bit wait counter SHALL clear on entry to ISSUE and RELEASE and increment each cycle spent there.
REQ-026 On reaching TIMEOUT, the FSM SHALL:
  - drive m_stb=0 and m_clk=0;
  - pulse err, not done, for the granted requester;
  - update round-robin as if served;
  - return to IDLE.
REQ-027 Deassertion of the granted req mid-transaction SHALL be ignored; the transaction SHALL complete and done SHALL still pulse.
REQ-028 Changes to the granted requester's addr, wdata, or we after grant SHALL not affect m_*.
REQ-029 rdata SHALL hold its last captured value outside done cycles; for writes it is undefined but stable.
REQ-030 done and err SHALL never be high in the same cycle; at most one requester's pulse SHALL be active per cycle.

Reset
REQ-031 While reset is high, the FSM SHALL enter IDLE, and grant, m_stb, m_clk, m_we, m_addr, m_wdata, done, err, and rdata SHALL all be 0.
REQ-032 The round-robin pointer SHALL reset to "r1 served last".
REQ-033 Reset mid-transaction SHALL drop m_clk and m_stb in the next cycle, so the UART returns its ack low; the aborted transaction SHALL produce no done or err pulse.

Structure
REQ-034 A shared package SHALL hold:
  - UART register address constants TX=0, RX=1, DIV=2;
  - the FSM state encoding;
  - the UART write polarity constant (write=0).
REQ-035 Round-robin selection SHALL be one sub-module, rr_arb2, with inputs req[1:0] and last, and output one-hot gnt; everything else SHALL be one flat module.

Verification
REQ-036 Single r0 write with addr=0, wdata=0x41, we=0 and a 1-cycle-ack slave -> m_addr=0, m_wdata=0x41, m_we=0 for the whole transaction; r0_done 4 cycles after req.
REQ-037 r1 read of addr=1 with slave m_rdata=0x5A -> r1_done pulse with rdata=0x5A in that same cycle; grant=10 during the transaction.
REQ-038 r0 and r1 both requesting continuously for 4 transactions -> grant sequence r0, r1, r0, r1; each done pulses exactly once per transaction.
REQ-039 Slave never acks, with TIMEOUT=8 -> err pulses after 8 ISSUE cycles; m_clk=0 and m_stb=0 the next cycle; no done; the other requester is granted next.
REQ-040 Reset asserted during RELEASE -> all outputs 0 the next cycle, no done or err; a fresh r0 request after reset wins a tie with r1.
REQ-041 Granted req dropped during ISSUE, and its wdata changed to 0xFF -> transaction completes with the original m_wdata; done still pulses.
